// File: rtl/seg_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scroll_ctrl
//  Description : Scrolling controller for a six-digit seven-segment display.
//                Buffers hex nibbles in a valid/ready FIFO and shifts them
//                into a six-entry digit register once every TICK_CYCLES
//                clock cycles. Digit code 16 means blank.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scroll_ctrl #(
    parameter int TICK_CYCLES = 5000000,
    parameter int DEPTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [3:0]                 in_data,
    output logic                       in_ready,
    input  logic                       clear,
    input  logic                       pause,
    output logic [4:0]                 h0,
    output logic [4:0]                 h1,
    output logic [4:0]                 h2,
    output logic [4:0]                 h3,
    output logic [4:0]                 h4,
    output logic [4:0]                 h5,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH + 1);
    localparam int c_CNT_W = $clog2(TICK_CYCLES);

    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TICK_CYCLES - 1);
    localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(DEPTH);
    localparam logic [4:0]         c_BLANK    = 5'd16;

    logic [3:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_LVL_W-1:0] r_level;
    logic [c_CNT_W-1:0] r_cnt;
    logic [4:0]         r_digits [6];

    logic w_full;
    logic w_tick;
    logic w_push;
    logic w_pop;

    // Handshake and scroll-step decode; pop only when the FIFO already held data
    always_comb begin
        w_full   = (r_level == c_LVL_FULL);
        in_ready = !w_full && !clear && !rst;
        w_push   = in_valid && in_ready;
        w_tick   = (r_cnt == c_CNT_MAX) && !pause;
        w_pop    = w_tick && (r_level != '0);
    end

    // FIFO storage; no reset needed since level gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    // Tick counter, FIFO pointers/occupancy and the digit shift register
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_cnt   <= '0;
            for (int i = 0; i < 6; i++) begin
                r_digits[i] <= c_BLANK;
            end
        end else begin
            if (!pause) begin
                r_cnt <= (r_cnt == c_CNT_MAX) ? '0 : r_cnt + 1'b1;
            end

            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            if (w_tick) begin
                for (int i = 5; i > 0; i--) begin
                    r_digits[i] <= r_digits[i-1];
                end
                r_digits[0] <= w_pop ? {1'b0, r_mem[r_rptr]} : c_BLANK;
            end
        end
    end

    // Registered state straight to the ports
    always_comb begin
        h0    = r_digits[0];
        h1    = r_digits[1];
        h2    = r_digits[2];
        h3    = r_digits[3];
        h4    = r_digits[4];
        h5    = r_digits[5];
        level = r_level;
    end

endmodule
`default_nettype wire
